systolic_mm: RTL

//  Parametrised output-stationary ROWSxCOLS systolic matrix-multiply engine, successor to the fixed 4x4 PE grid.

---
 rtl/systolic_pkg.sv | 40 ++++
 rtl/systolic_pe.sv | 67 ++++++
 rtl/systolic_mm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type, width defaults and saturating add
// for the systolic_mm matrix-multiply engine and its PE cells.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 16;
  localparam int K_MAX_DEF      = 255;

  // Add two signed values and clamp to a w-bit signed range.
  // Operands arrive sign-extended to 64 bits, so the raw sum
  // cannot overflow for any w up to 62. A saturated input plus
  // a same-sign addend clamps again, which keeps it sticky.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi;
    end
    if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one output-stationary MAC cell. Ports: clk/rst, en_i (MAC
// enable), clr_i (clear acc), a_i/b_i in, a_o/b_o registered pass-through,
// acc_o accumulator. ACC_SAT_EN selects saturating instead of wrapping add.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]       a_q;
  logic [DATA_WIDTH-1:0]       b_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [PW-1:0]        a_x;
  logic signed [PW-1:0]        b_x;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_x;

  // Full signed product always fits in 2*DATA_WIDTH bits.
  assign a_x    = PW'($signed(a_i));
  assign b_x    = PW'($signed(b_i));
  assign prod   = a_x * b_x;
  assign prod_x = ACC_WIDTH'(prod);

  always_comb begin
    acc_d = acc_q;
`ifdef ACC_SAT_EN
    acc_d = ACC_WIDTH'(sat_add(64'(acc_q), 64'(prod_x), ACC_WIDTH));
`else
    acc_d = acc_q + prod_x;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (clr_i) begin
        acc_q <= '0;
      end else if (en_i) begin
        acc_q <= acc_d;
      end
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm.sv
// systolic_mm: ROWSxCOLS output-stationary systolic C=A*B engine with input
// skew, start/busy/done FSM and valid/ready beats. Ports: clk, rst, start,
// k_len, in_valid/in_ready, a_in, b_in, busy, done, out_valid, data_out.
// ACC_SAT_EN selects saturating accumulators (default: wrap).
module systolic_mm
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int K_MAX      = K_MAX_DEF,
  localparam int KW        = $clog2(K_MAX + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]     a_in,
  input  logic [COLS*DATA_WIDTH-1:0]     b_in,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  output logic [ROWS*COLS*ACC_WIDTH-1:0] data_out
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int FW = $clog2(ROWS + COLS);
  localparam int FLUSH_LAST = ROWS + COLS - 2;

  state_e        state_q;
  state_e        state_d;
  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;
  logic [KW-1:0] beat_q;
  logic [KW-1:0] beat_d;
  logic [FW-1:0] fl_q;
  logic [FW-1:0] fl_d;
  logic          done_q;
  logic          done_d;
  logic          clr;
  logic          mac_en;
  logic          accept;

  logic [DW-1:0] a_g  [ROWS];
  logic [DW-1:0] b_g  [COLS];
  logic [DW-1:0] a_sk [ROWS];
  logic [DW-1:0] b_sk [COLS];
  logic [DW-1:0] a_w  [ROWS][COLS+1];
  logic [DW-1:0] b_w  [ROWS+1][COLS];
  logic [AW-1:0] acc_w [ROWS][COLS];
  logic [ROWS-1:0] unused_a;
  logic [COLS-1:0] unused_b;

  assign accept = in_valid && (state_q == LOAD);
  assign mac_en = (state_q == LOAD) || (state_q == FLUSH);

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    beat_d  = beat_q;
    fl_d    = fl_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clr    = 1'b1;
          k_d    = k_len;
          beat_d = '0;
          if (k_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_d == k_q) begin
            // Counts FLUSH cycles from 1 so the exit compare
            // lands on the cycle of the final corner MAC.
            fl_d = FW'(1);
            if (FLUSH_LAST == 0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (fl_q == FW'(FLUSH_LAST)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          fl_d = fl_q + FW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      fl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      fl_q    <= fl_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q == LOAD) || (state_q == FLUSH);
  assign done      = done_q;
  assign out_valid = (state_q == DONE);

  // ---------------- input gating and skew ----------------
  // Cycles without an accepted beat push zeros (bubbles).
  for (genvar i = 0; i < ROWS; i++) begin : g_arow
    assign a_g[i] = accept ? a_in[i*DW +: DW] : '0;
    if (i == 0) begin : g_nodly
      assign a_sk[i] = a_g[i];
    end else begin : g_dly
      logic [DW-1:0] sr_q [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < i; d++) begin
            sr_q[d] <= '0;
          end
        end else begin
          sr_q[0] <= a_g[i];
          for (int d = 1; d < i; d++) begin
            sr_q[d] <= sr_q[d-1];
          end
        end
      end
      assign a_sk[i] = sr_q[i-1];
    end
    assign a_w[i][0]   = a_sk[i];
    assign unused_a[i] = ^a_w[i][COLS];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bcol
    assign b_g[j] = accept ? b_in[j*DW +: DW] : '0;
    if (j == 0) begin : g_nodly
      assign b_sk[j] = b_g[j];
    end else begin : g_dly
      logic [DW-1:0] sr_q [j];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int d = 0; d < j; d++) begin
            sr_q[d] <= '0;
          end
        end else begin
          sr_q[0] <= b_g[j];
          for (int d = 1; d < j; d++) begin
            sr_q[d] <= sr_q[d-1];
          end
        end
      end
      assign b_sk[j] = sr_q[j-1];
    end
    assign b_w[0][j]   = b_sk[j];
    assign unused_b[j] = ^b_w[ROWS][j];
  end

  // ---------------- PE grid ----------------
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (clr),
        .a_i   (a_w[i][j]),
        .b_i   (b_w[i][j]),
        .a_o   (a_w[i][j+1]),
        .b_o   (b_w[i+1][j]),
        .acc_o (acc_w[i][j])
      );
      assign data_out[(i*COLS+j)*AW +: AW] = acc_w[i][j];
    end
  end

endmodule
